// File: rtl/seq_circuit_pkg.sv
// Shared types, defaults and next-state logic for the multi-lane A/B sequential circuit.
package seq_circuit_pkg;

    localparam int LANES_DEF   = 4;
    localparam int CNT_W_DEF   = 8;
    localparam bit OUT_REG_DEF = 1'b0;

    // Two state bits of one lane.
    typedef struct packed {
        logic y;
        logic t;
    } lane_state_t;

    // d_y = a | (b & t); d_t = ~(d_y | y)
    function automatic lane_state_t next_state(input logic a, input logic b,
                                               input lane_state_t cur);
        lane_state_t nxt;
        logic        s;
        s     = b & cur.t;
        nxt.y = a | s;
        nxt.t = ~(nxt.y | cur.y);
        return nxt;
    endfunction

endpackage

// File: rtl/seq_circuit_lane.sv
// One lane: state flops, Mealy output, optional output register and a
// saturating rising-edge counter on Z.
module seq_circuit_lane
    import seq_circuit_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEF,
    parameter bit OUT_REG = OUT_REG_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic             clr_cnt_i,
    input  logic             a_i,
    input  logic             b_i,
    output logic             y_o,
    output logic             t_o,
    output logic             s_o,
    output logic             z_o,
    output logic [CNT_W-1:0] cnt_o
);

    lane_state_t      state_q, state_d;
    logic             z_m;
    logic             z;
    logic             z_prev_q;
    logic             rise;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign s_o = b_i & state_q.t;
    assign z_m = state_q.y | s_o;

    // Next state only advances when enabled; otherwise the lane holds.
    always_comb begin
        state_d = state_q;
        if (en_i) state_d = next_state(a_i, b_i, state_q);
    end

    // Lane state register.
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= '0;
        else        state_q <= state_d;
    end

    // Z is either the raw Mealy term or that term delayed one edge; the
    // delay register runs every edge regardless of EN.
    generate
        if (OUT_REG) begin : g_zreg
            logic z_q;
            // Output register, free-running.
            always_ff @(posedge clk) begin
                if (!rst_n) z_q <= 1'b0;
                else        z_q <= z_m;
            end
            assign z = z_q;
        end else begin : g_zcomb
            assign z = z_m;
        end
    endgenerate

    assign rise = z & ~z_prev_q;

    // Clear beats a coincident rise; the count sticks at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_cnt_i)                           cnt_d = '0;
        else if (rise && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
    end

    // Edge-detect history and counter; z_prev tracks Z even during a clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            z_prev_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            z_prev_q <= z;
            cnt_q    <= cnt_d;
        end
    end

    assign y_o   = state_q.y;
    assign t_o   = state_q.t;
    assign z_o   = z;
    assign cnt_o = cnt_q;

endmodule

// File: rtl/seq_circuit_vec.sv
// LANES independent A/B sequential-circuit lanes with packed edge counters
// and a combined any-Z flag.
module seq_circuit_vec
    import seq_circuit_pkg::*;
#(
    parameter int LANES   = LANES_DEF,
    parameter int CNT_W   = CNT_W_DEF,
    parameter bit OUT_REG = OUT_REG_DEF
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   EN,
    input  logic                   CLR_CNT,
    input  logic [LANES-1:0]       A,
    input  logic [LANES-1:0]       B,
    output logic [LANES-1:0]       Y,
    output logic [LANES-1:0]       T,
    output logic [LANES-1:0]       S,
    output logic [LANES-1:0]       Z,
    output logic [LANES*CNT_W-1:0] CNT,
    output logic                   ANY_Z
);

    generate
        for (genvar i = 0; i < LANES; i++) begin : g_lane
            seq_circuit_lane #(
                .CNT_W   (CNT_W),
                .OUT_REG (OUT_REG)
            ) u_lane (
                .clk       (CLK),
                .rst_n     (RST),
                .en_i      (EN),
                .clr_cnt_i (CLR_CNT),
                .a_i       (A[i]),
                .b_i       (B[i]),
                .y_o       (Y[i]),
                .t_o       (T[i]),
                .s_o       (S[i]),
                .z_o       (Z[i]),
                .cnt_o     (CNT[i*CNT_W +: CNT_W])
            );
        end
    endgenerate

    assign ANY_Z = |Z;

endmodule

// File: doc/seq_circuit_vec.md
# seq_circuit_vec

Parametrised, multi-lane successor to the team's two-flip-flop A/B sequential circuit. Each of LANES independent lanes runs the same two-state-bit machine, computes the Mealy output Z, and optionally registers it. Each lane also counts rising edges of Z in a saturating counter. It sits in the lab datapath wherever several A/B channels need the circuit in parallel with event statistics, replacing per-channel hand instantiation.

## Interface
- LANES, 4, number of independent lanes (1..32)
- CNT_W, 8, width of each per-lane edge counter (2..16)
- OUT_REG, 0, 0 = Z is combinational (Mealy); 1 = Z registered one cycle
- CLK  in  1  single clock, all state updates on rising edge
- RST  in  1  synchronous, active-low reset; RST=0 at a rising CLK edge resets everything
- EN  in  1  state-update enable, common to all lanes
- CLR_CNT  in  1  synchronous clear of all edge counters
- A  in  LANES  per-lane input A
- B  in  LANES  per-lane input B
- Y  out  LANES  per-lane state bit y
- T  out  LANES  per-lane state bit t
- S  out  LANES  per-lane set term, B & t (combinational)
- Z  out  LANES  per-lane output (see OUT_REG)
- CNT  out  LANES*CNT_W  packed counters, lane i at [i*CNT_W +: CNT_W]
- ANY_Z  out  1  OR of all Z bits

## Operation
- Per lane i, state is (y, t).
  - s = b & t
  - d_y = a | s
  - d_t = ~(d_y | y)
- On a CLK edge with EN=1: y <= d_y, t <= d_t. With EN=0: y and t hold.
- Mealy output: z_m = y | s.
  - OUT_REG=0: Z = z_m. It follows B combinationally even when EN=0.
  - OUT_REG=1: Z is z_m sampled every edge, independent of EN.
- Edge detect: z_prev <= Z every edge. A rise is Z=1 & z_prev=0.
- Counter behaviour:
  - On a rise, the counter increments by 1.
  - It saturates at 2^CNT_W-1 and never wraps.
- CLR_CNT=1 clears all counters to 0. Clear wins over a coincident rise, which is not counted. z_prev still updates.
- Lanes are fully independent. EN, CLR_CNT and RST apply to all lanes.

## Timing
- Reset (RST=0 at edge) sets y=0, t=0, z_prev=0, CNT=0, and the registered Z to 0.
- After reset: Y=0, T=0, S=0, CNT=0, ANY_Z=0. Z=0 in both modes, since z_m=0 when y=t=0.
- RST=0 overrides EN and CLR_CNT. Reset in the middle of a sequence discards state on that edge.
- State latency: one edge from A/B sampled to Y/T.
- Z latency:
  - OUT_REG=0: 0 cycles from B, 1 cycle from A.
  - OUT_REG=1: one more cycle than OUT_REG=0.
- Counter latency: CNT reflects a rise one edge after Z rises. In OUT_REG=1 mode that is two edges after z_m rises.
- Reset-state sequence with a=0, b=0 and EN=1: (0,0) → (0,1). From (0,1) with b=1: (1,0), with Z=1 during the (0,1) cycle. From (1,0) with a=0, b=0: (0,0).

## Structure
- Package seq_circuit_pkg holds:
  - localparam defaults for LANES, CNT_W and OUT_REG
  - typedef struct lane_state_t {y, t}
  - a function next_state(a, b, lane_state_t)
- Sub-module seq_circuit_lane (parameters CNT_W, OUT_REG) implements one lane: state flops, z_m, optional Z register, z_prev and the saturating counter.
- The top level generate-loops seq_circuit_lane LANES times, packs CNT and ORs the Z bits into ANY_Z.
- No gate delays are modelled. The block is purely synchronous RTL.

## Test plan
- Reset: drive RST=0 for 2 edges with random A/B/EN/CLR_CNT → Y=T=0, Z=0, CNT=0, ANY_Z=0. Release RST → the first state change appears one edge later.
- Cycle walk, lane 0, OUT_REG=0, EN=1:
  - From reset, a=0, b=0 → (0,1).
  - Then b=1 → Z=1 immediately, S=1, next state (1,0).
  - Then a=0, b=0 → (0,0).
  - CNT[0] reads 1 one edge after the Z rise.
- Hold: at state (0,1), set EN=0 and toggle B 0/1/0 → Y/T stay (0,1), Z tracks B, CNT[0] rises by 1 per B rising edge.
- Saturation: CNT_W=2, force 5 Z rises → CNT saturates at 3 and stays there. A CLR_CNT coinciding with a rise → CNT=0 on that edge.
- OUT_REG=1: repeat the cycle-walk stimulus → Z rises one edge after z_m. CNT increments two edges after the B rise. Z=0 out of reset.
- Lane independence: LANES=4, drive lane 2 only with a=1 → Y=4'b0100 after one edge, other lanes unaffected, ANY_Z=1.
